// File: rtl/char_blitter_if.sv
// Command, glyph-ROM and VGA plot signals of the character blitter.
// The blitter (slave) takes commands and ROM data and produces plot strobes.
interface char_blitter_if;
  logic       start;
  logic [4:0] char_index;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic [2:0] fg_colour;
  logic [2:0] bg_colour;
  logic       opaque;
  logic [9:0] rom_addr;
  logic       rom_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport slave (
    input  start, char_index, origin_x, origin_y, fg_colour, bg_colour, opaque, rom_data,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport master (
    output start, char_index, origin_x, origin_y, fg_colour, bg_colour, opaque, rom_data,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/char_blitter.sv
// Draws one glyph from a synchronous 1-bit glyph ROM onto the screen,
// clipping at the right/bottom edge; three-stage address->data->plot pipeline.
module char_blitter #(
  parameter int unsigned CHAR_W = 5,
  parameter int unsigned CHAR_H = 5,
  parameter int unsigned XMAX   = 159,
  parameter int unsigned YMAX   = 119
) (
  input  logic          clk,
  input  logic          resetn,
  char_blitter_if.slave bus
);
  localparam int unsigned GLYPH = CHAR_W * CHAR_H;
  localparam int unsigned CXW   = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int unsigned CYW   = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int unsigned AW    = 10;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;
  localparam int unsigned IW    = 5;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic            w_accept, w_last, w_row_end;
  logic [CXW-1:0]  r_cx, w_cx_n;
  logic [CYW-1:0]  r_cy, w_cy_n;
  logic            r_drain;
  logic [IW-1:0]   r_char;
  logic [XW-1:0]   r_ox;
  logic [YW-1:0]   r_oy;
  logic [CW-1:0]   r_fg, r_bg;
  logic            r_opaque;
  logic [AW-1:0]   r_rom_addr, w_addr_n;
  logic [XW:0]     w_scr_x;
  logic [YW:0]     w_scr_y;
  logic            w_on_screen;
  logic            r_p_valid;
  logic [XW-1:0]   r_p_x;
  logic [YW-1:0]   r_p_y;
  logic            w_plot;
  logic [XW-1:0]   r_vga_x;
  logic [YW-1:0]   r_vga_y;
  logic [CW-1:0]   r_vga_colour;
  logic            r_vga_plot;
  logic            r_busy, r_done;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_row_end = (r_cx == CXW'(CHAR_W - 1));
    w_last    = (r_state == S_SCAN) && w_row_end && (r_cy == CYW'(CHAR_H - 1));
    case (r_state)
      S_IDLE:  if (bus.start) begin
                 w_accept  = 1'b1;
                 w_state_n = S_SCAN;
               end
      S_SCAN:  if (w_last) w_state_n = S_DRAIN;
      S_DRAIN: if (r_drain) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Scan position, next ROM address and clipped screen position
  always_comb begin
    w_cx_n      = w_row_end ? '0 : r_cx + CXW'(1);
    w_cy_n      = w_row_end ? r_cy + CYW'(1) : r_cy;
    w_addr_n    = AW'(r_char) * AW'(GLYPH) + AW'(w_cy_n) * AW'(CHAR_W) + AW'(w_cx_n);
    w_scr_x     = (XW+1)'(r_ox) + (XW+1)'(r_cx);
    w_scr_y     = (YW+1)'(r_oy) + (YW+1)'(r_cy);
    w_on_screen = (w_scr_x <= (XW+1)'(XMAX)) && (w_scr_y <= (YW+1)'(YMAX));
    w_plot      = r_p_valid && (bus.rom_data || r_opaque);
  end

  // Command latch, scan counters and plot pipeline
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_drain      <= 1'b0;
      r_char       <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_fg         <= '0;
      r_bg         <= '0;
      r_opaque     <= 1'b0;
      r_rom_addr   <= '0;
      r_p_valid    <= 1'b0;
      r_p_x        <= '0;
      r_p_y        <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_char     <= bus.char_index;
        r_ox       <= bus.origin_x;
        r_oy       <= bus.origin_y;
        r_fg       <= bus.fg_colour;
        r_bg       <= bus.bg_colour;
        r_opaque   <= bus.opaque;
        r_cx       <= '0;
        r_cy       <= '0;
        r_rom_addr <= AW'(bus.char_index) * AW'(GLYPH);
      end else if (r_state == S_SCAN) begin
        if (w_last) begin
          r_cx       <= '0;
          r_cy       <= '0;
          r_rom_addr <= '0;
        end else begin
          r_cx       <= w_cx_n;
          r_cy       <= w_cy_n;
          r_rom_addr <= w_addr_n;
        end
      end
      r_drain <= (r_state == S_DRAIN) && !r_drain;

      // Stage 1 carries the position alongside the ROM read; stage 2 meets the data
      r_p_valid    <= (r_state == S_SCAN) && w_on_screen;
      r_p_x        <= w_scr_x[XW-1:0];
      r_p_y        <= w_scr_y[YW-1:0];
      r_vga_plot   <= w_plot;
      r_vga_x      <= w_plot ? r_p_x : '0;
      r_vga_y      <= w_plot ? r_p_y : '0;
      r_vga_colour <= w_plot ? (bus.rom_data ? r_fg : r_bg) : '0;

      r_busy <= (w_state_n != S_IDLE);
      r_done <= (w_state_n == S_DONE);
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.vga_plot   = r_vga_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
